// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: open-drain line drivers, device-clocked bit shifting.
// Optional transfer watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, START, DATA, PARITY, ACK, WAIT_IDLE
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync, data_sync;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [3:0]    bitcnt;
  logic          parity, ack;
  logic          fall, bus_idle, timeout;

  // Pins idle high through pull-ups, so the synchronisers reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 3'b111;
      data_sync <= 3'b111;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
    end
  end

  // data_sync[1] lines up with the sample that shows clk low, so the ACK is read at the fall itself.
  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign bus_idle = &{clk_sync[2:1], data_sync[2:1]};

`ifdef PS2_TX_TIMEOUT_EN
  logic in_bus;
  assign in_bus  = state inside {START, DATA, PARITY, ACK, WAIT_IDLE};
  assign timeout = in_bus && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_ack_ok   <= 1'b0;
      tx_err      <= 1'b0;
      cnt         <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      ack         <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (timeout) begin
        // Expiry outranks a coincident fall: abandon the frame and free the bus.
        state       <= IDLE;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_ready    <= 1'b1;
        tx_done     <= 1'b1;
        tx_ack_ok   <= 1'b0;
        tx_err      <= 1'b1;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (tx_valid && tx_ready) begin
              shreg      <= tx_data;
              parity     <= ~^tx_data;
              cnt        <= '0;
              bitcnt     <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              tx_ack_ok  <= 1'b0;
              tx_err     <= 1'b0;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            // Our own clock pull-down shows up as a fall here; it is outside START..ACK and ignored.
            if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= START;
          end
          START: begin
            if (fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[7:1]};
              bitcnt      <= 4'd1;
              state       <= DATA;
            end
          end
          DATA: begin
            if (fall) begin
              if (bitcnt == 4'd8) begin
                ps2_data_oe <= ~parity;
                state       <= PARITY;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[7:1]};
                bitcnt      <= bitcnt + 4'd1;
              end
            end
          end
          PARITY: begin
            if (fall) begin
              ps2_data_oe <= 1'b0;
              state       <= ACK;
            end
          end
          ACK: begin
            if (fall) begin
              ack   <= ~data_sync[1];
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (bus_idle) begin
              tx_done   <= 1'b1;
              tx_ack_ok <= ack;
              tx_err    <= ~ack;
              tx_ready  <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (in_bus) cnt <= cnt + CW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a clock-generating PS/2 device model on the open-drain pins.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_ack_ok, tx_err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  wire        ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done),
    .tx_ack_ok(tx_ack_ok), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_pass = 0;
  logic       seen_done, done_ack, done_err;
  logic [9:0] rx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (tx_done === 1'b1) begin
      seen_done = 1'b1;
      done_ack  = tx_ack_ok;
      done_err  = tx_err;
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    int n;
    tx_data = d; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ready_drop", tx_ready, 0);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 5000) begin
      n++;
      tick();
    end
    chk("inhibit_len", n, INH);
    chk("req_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    tick();
    chk("start_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  // Device: 11 falls, samples data at each rise, optional ACK low at the 11th fall.
  task automatic dev_run(input logic ack_low, input int abort_at);
    repeat (4) tick();
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (4) tick();
        return;
      end
      repeat (6) tick();
      if (k <= 10) rx[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (6) tick();
      if (k == 10) dev_data_low = ack_low;
    end
    repeat (3) tick();
    dev_data_low = 1'b0;
  endtask

  task automatic do_tx(input logic [7:0] d, input logic par, input logic ack_low);
    seen_done = 1'b0; done_ack = 1'b0; done_err = 1'b0; rx = '0;
    start_tx(d);
    dev_run(ack_low, 0);
    for (int i = 0; i < 20 && !seen_done; i++) tick();
    chk("data_bits", rx[7:0], d);
    chk("parity_bit", rx[8], par);
    chk("stop_bit", rx[9], 1);
    chk("done_pulse", seen_done, 1);
    chk("ack_ok", done_ack, ack_low);
    chk("err", done_err, !ack_low);
    chk("ready_after", tx_ready, 1);
    chk("oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("ack_hold", tx_ack_ok, ack_low);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_ready", tx_ready, 1);
    chk("rst_flags", {tx_done, tx_ack_ok, tx_err}, 3'b000);
    reset = 1'b0;
    tick();

    do_tx(8'hED, 1'b1, 1'b1);
    do_tx(8'h01, 1'b0, 1'b1);
    do_tx(8'hFF, 1'b1, 1'b1);
    do_tx(8'h00, 1'b1, 1'b1);
    do_tx(8'hAA, 1'b1, 1'b0);

    // Reset after the 4th device fall, then a fresh transfer.
    seen_done = 1'b0; rx = '0;
    start_tx(8'h3C);
    dev_run(1'b1, 4);
    reset = 1'b1;
    tick();
    dev_clk_low = 1'b0;
    chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_done", tx_done, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_no_done", seen_done, 0);
    do_tx(8'hF4, 1'b0, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int c;
      seen_done = 1'b0; done_ack = 1'b1; done_err = 1'b0;
      start_tx(8'h55);
      c = 0;
      while (!seen_done && c < 400) begin
        c++;
        tick();
      end
      chk("tmo_cycles", c, TMO);
      chk("tmo_err", done_err, 1);
      chk("tmo_ack", done_ack, 0);
      chk("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      chk("tmo_ready", tx_ready, 1);
    end
`else
    seen_done = 1'b0;
    start_tx(8'h55);
    repeat (300) tick();
    chk("stall_busy", tx_ready, 0);
    chk("stall_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    chk("stall_no_done", seen_done, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("stall_rst_ready", tx_ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
